// File: rtl/calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_pkg : shared types and helpers for the calculator token path
// Rev 1.0
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DIGIT    = 4'd1,
    S_ECHO_OP  = 4'd2,
    S_PUSH_NUM = 4'd3,
    S_PUSH_OP  = 4'd4,
    S_WAIT_ANS = 4'd5,
    S_SHOW_ANS = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_e;

  localparam logic [3:0] EQ_CODE_DEF   = 4'hF;
  localparam int         OP_WORD_MAX_W = 64;

  // Operator word: MSB of the data_w-wide word set, token zero-extended below it.
  function automatic logic [OP_WORD_MAX_W-1:0] make_op_word(input logic [15:0] token,
                                                             input int unsigned data_w);
    return (64'd1 << (data_w - 1)) | {48'd0, token};
  endfunction

endpackage
`default_nettype wire

// File: rtl/number_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// number_accumulator : builds a binary operand from radix digits
// Rev 1.0
// ---------------------------------------------------------------------------
module number_accumulator
  import calc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TOKEN_W = 4,
  parameter int RADIX   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load_digit,
  input  logic [TOKEN_W-1:0] digit,
  output logic [DATA_W-1:0]  acc,
  output logic               have_num,
  output logic               overflow,
  output logic               bad_digit
);

  // Wide enough that acc*RADIX + digit can never wrap, so the overflow test is exact.
  localparam int PROD_W = DATA_W + $clog2(RADIX) + 1;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              have_num_q, have_num_d;
  logic [PROD_W-1:0] acc_ext, digit_ext, radix_ext, next_ext;

  always_comb begin
    acc_ext   = PROD_W'(acc_q);
    digit_ext = PROD_W'(digit);
    radix_ext = PROD_W'(RADIX);
    next_ext  = acc_ext * radix_ext + digit_ext;
    bad_digit = (digit_ext >= radix_ext);
    overflow  = |next_ext[PROD_W-1:DATA_W];
  end

  always_comb begin
    acc_d      = acc_q;
    have_num_d = have_num_q;
    if (clear) begin
      acc_d      = '0;
      have_num_d = 1'b0;
    end else if (load_digit && !overflow && !bad_digit) begin
      acc_d      = next_ext[DATA_W-1:0];
      have_num_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      have_num_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      have_num_q <= have_num_d;
    end
  end

  assign acc      = acc_q;
  assign have_num = have_num_q;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_sequencer : decoder-to-ffcalc token sequencer with display echo
// Rev 1.0
// ---------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter int                 TOKEN_W = 4,
  parameter int                 RADIX   = 10,
  parameter logic [TOKEN_W-1:0] EQ_CODE = TOKEN_W'(EQ_CODE_DEF)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tok_valid,
  input  logic                        tok_is_number,
  input  logic [TOKEN_W-1:0]          tok_data,
  output logic                        tok_ready,
  output logic                        calc_valid,
  output logic [DATA_W-1:0]           calc_data,
  input  logic                        calc_ready,
  input  logic                        ans_valid,
  input  logic [DATA_W-1:0]           ans_data,
  output logic                        disp_we,
  output logic [DATA_W-1:0]           disp_data,
  output logic [$clog2(DATA_W+1)-1:0] disp_size,
  output logic                        done,
  output logic                        err,
  output logic [3:0]                  state_dbg
);

  localparam int SIZE_W = $clog2(DATA_W+1);

  state_e               state_q, state_d;
  logic                 rdy_en_q;
  logic [TOKEN_W-1:0]   tok_q;
  logic [DATA_W-1:0]    ans_q;
  logic [DATA_W-1:0]    acc_val;
  logic                 have_num;
  logic                 acc_ovf;
  logic                 acc_bad;
  logic                 accept;
  logic                 acc_load;
  logic                 acc_clear;
  logic [OP_WORD_MAX_W-1:0] op_word_full;

  assign accept    = tok_valid && tok_ready;
  assign acc_load  = accept && tok_is_number;
  assign acc_clear = (state_q == S_PUSH_NUM) && calc_ready;

  // tok_q holds the last accepted token; it doubles as the latched operator
  // because no token is accepted between ECHO_OP and the end of PUSH_OP.
  assign op_word_full = make_op_word(16'(tok_q), DATA_W);

  generate
    if (DATA_W < OP_WORD_MAX_W) begin : g_op_hi
      logic unused_op_hi;
      assign unused_op_hi = ^op_word_full[OP_WORD_MAX_W-1:DATA_W];
    end
  endgenerate

  number_accumulator #(
    .DATA_W  (DATA_W),
    .TOKEN_W (TOKEN_W),
    .RADIX   (RADIX)
  ) u_acc (
    .clock      (clock),
    .reset      (reset),
    .clear      (acc_clear),
    .load_digit (acc_load),
    .digit      (tok_data),
    .acc        (acc_val),
    .have_num   (have_num),
    .overflow   (acc_ovf),
    .bad_digit  (acc_bad)
  );

  // rdy_en_q keeps tok_ready low throughout reset without a reset-to-output path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tok_q <= '0;
      ans_q <= '0;
    end else begin
      if (accept) begin
        tok_q <= tok_data;
      end
      if ((state_q == S_WAIT_ANS) && ans_valid) begin
        ans_q <= ans_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (tok_is_number) begin
            state_d = (acc_ovf || acc_bad) ? S_ERROR : S_DIGIT;
          end else if (have_num) begin
            state_d = S_ECHO_OP;
          end
        end
      end
      S_DIGIT:    state_d = S_IDLE;
      S_ECHO_OP:  state_d = S_PUSH_NUM;
      S_PUSH_NUM: if (calc_ready) state_d = S_PUSH_OP;
      S_PUSH_OP: begin
        if (calc_ready) begin
          state_d = (tok_q == EQ_CODE) ? S_WAIT_ANS : S_IDLE;
        end
      end
      S_WAIT_ANS: if (ans_valid) state_d = S_SHOW_ANS;
      S_SHOW_ANS: state_d = S_DONE;
      S_DONE:     state_d = S_DONE;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tok_ready  = 1'b0;
    calc_valid = 1'b0;
    calc_data  = '0;
    disp_we    = 1'b0;
    disp_data  = '0;
    disp_size  = '0;
    done       = 1'b0;
    err        = 1'b0;
    state_dbg  = state_q;
    case (state_q)
      S_IDLE: tok_ready = rdy_en_q;
      S_DIGIT, S_ECHO_OP: begin
        disp_we   = 1'b1;
        disp_data = DATA_W'(tok_q);
        disp_size = SIZE_W'(TOKEN_W);
      end
      S_PUSH_NUM: begin
        calc_valid = 1'b1;
        calc_data  = acc_val;
      end
      S_PUSH_OP: begin
        calc_valid = 1'b1;
        calc_data  = op_word_full[DATA_W-1:0];
      end
      S_SHOW_ANS: begin
        disp_we   = 1'b1;
        disp_data = ans_q;
        disp_size = SIZE_W'(DATA_W);
      end
      S_DONE:  done = 1'b1;
      S_ERROR: err  = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
